// File: rtl/pe_cfg_pkg.sv
// rtl/pe_cfg_pkg.sv - shared sizes, control-word fields and sequencer states
package pe_cfg_pkg;

  localparam int NUM_PE  = 4;
  localparam int NUM_CTX = 4;
  localparam int CTRL_W  = 8;

  localparam int SEL_OP0_MSB = 7;
  localparam int SEL_OP0_LSB = 5;
  localparam int SEL_OP1_MSB = 4;
  localparam int SEL_OP1_LSB = 2;
  localparam int ALU_OP_MSB  = 1;
  localparam int ALU_OP_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } seq_state_e;

endpackage

// File: rtl/pe_ctx_mem.sv
// rtl/pe_ctx_mem.sv - context store: nibble-wide write port, whole-context read port
module pe_ctx_mem #(
  parameter int NUM_PE  = 4,
  parameter int NUM_CTX = 4,
  parameter int CTRL_W  = 8,
  parameter int PTR_W   = 5,
  parameter int CTX_W   = 2
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [PTR_W-1:0]         wr_ptr,
  input  logic [3:0]               wr_nibble,
  input  logic [CTX_W-1:0]         rd_ctx,
  output logic [NUM_PE*CTRL_W-1:0] rd_data
);

  logic [CTRL_W-1:0] mem_q [NUM_CTX][NUM_PE];
  int wr_word;
  int wr_c;
  int wr_p;

  // Linear nibble pointer walks pe fastest, then ctx; bit 0 picks the half.
  always_comb begin
    wr_word = int'(wr_ptr) >> 1;
    wr_c    = wr_word / NUM_PE;
    wr_p    = wr_word % NUM_PE;
  end

  // No reset: the sequencer's loaded flag keeps stale contents from running.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_c][wr_p][{wr_ptr[0], 2'b00} +: 4] <= wr_nibble;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      rd_data[p*CTRL_W +: CTRL_W] = mem_q[rd_ctx][p];
    end
  end

endmodule

// File: rtl/pe_array_sequencer.sv
// rtl/pe_array_sequencer.sv - loads PE contexts and steps them through a PE array
module pe_array_sequencer
  import pe_cfg_pkg::*;
#(
  parameter int NUM_PE  = pe_cfg_pkg::NUM_PE,
  parameter int NUM_CTX = pe_cfg_pkg::NUM_CTX,
  parameter int CTRL_W  = pe_cfg_pkg::CTRL_W,
  localparam int CTX_W  = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  localparam int NIBS   = 2 * NUM_PE * NUM_CTX,
  localparam int PTR_W  = (NIBS > 1) ? $clog2(NIBS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_load,
  input  logic                     cfg_valid,
  input  logic [3:0]               cfg_data,
  output logic                     cfg_ready,
  input  logic                     start,
  input  logic [3:0]               run_len,
  input  logic                     stop,
  output logic [NUM_PE*CTRL_W-1:0] pe_ctrl,
  output logic [NUM_PE-1:0]        pe_en,
  output logic                     res_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_loaded,
  output logic [CTX_W-1:0]         ctx_idx
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NIBS - 1);
  localparam logic [CTX_W-1:0] LAST_CTX = CTX_W'(NUM_CTX - 1);

  seq_state_e               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [CTX_W-1:0]         ctx_q, ctx_d;
  logic                     loaded_q, loaded_d;
  logic                     wr_en;
  logic [NUM_PE*CTRL_W-1:0] rd_data;

  logic [NUM_PE*CTRL_W-1:0] pe_ctrl_q, pe_ctrl_d;
  logic [NUM_PE-1:0]        pe_en_q;
  logic                     res_valid_q, busy_q, done_q, cfg_ready_q;

  pe_ctx_mem #(
    .NUM_PE (NUM_PE),
    .NUM_CTX(NUM_CTX),
    .CTRL_W (CTRL_W),
    .PTR_W  (PTR_W),
    .CTX_W  (CTX_W)
  ) u_ctx_mem (
    .clock    (clock),
    .wr_en    (wr_en),
    .wr_ptr   (ptr_q),
    .wr_nibble(cfg_data),
    .rd_ctx   (ctx_d),
    .rd_data  (rd_data)
  );

  // cnt_q holds the steps remaining after the current one; run_len 0 wraps to 16 steps.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ctx_d    = ctx_q;
    loaded_d = loaded_q;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          state_d  = ST_LOAD;
          ptr_d    = '0;
          loaded_d = 1'b0;
        end else if (start && loaded_q) begin
          state_d = ST_RUN;
          cnt_d   = run_len - 4'd1;
          ctx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_load) begin
          ptr_d = '0;
        end else if (cfg_valid && cfg_ready_q) begin
          wr_en = 1'b1;
          if (ptr_q == LAST_PTR) begin
            state_d  = ST_IDLE;
            ptr_d    = '0;
            loaded_d = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop || cnt_q == 4'd0) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 4'd1;
          ctx_d = (ctx_q == LAST_CTX) ? '0 : ctx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pe_ctrl_d = (state_d == ST_RUN) ? rd_data : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ctx_q       <= '0;
      loaded_q    <= 1'b0;
      pe_ctrl_q   <= '0;
      pe_en_q     <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ctx_q       <= ctx_d;
      loaded_q    <= loaded_d;
      pe_ctrl_q   <= pe_ctrl_d;
      pe_en_q     <= {NUM_PE{state_d == ST_RUN}};
      res_valid_q <= (state_q == ST_RUN);
      busy_q      <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q      <= (state_q == ST_DRAIN);
      cfg_ready_q <= (state_d == ST_LOAD);
    end
  end

  assign pe_ctrl    = pe_ctrl_q;
  assign pe_en      = pe_en_q;
  assign res_valid  = res_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_loaded = loaded_q;
  assign cfg_ready  = cfg_ready_q;
  assign ctx_idx    = ctx_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// tb/tb_pe_array_sequencer.sv - randomized bench for pe_array_sequencer against a context/run model
module tb_pe_array_sequencer;

  localparam int NUM_PE  = 4;
  localparam int NUM_CTX = 4;
  localparam int CTRL_W  = 8;
  localparam int NIBS    = 2 * NUM_PE * NUM_CTX;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     cfg_load, cfg_valid, start, stop;
  logic [3:0]               cfg_data, run_len;
  logic                     cfg_ready, res_valid, busy, done, cfg_loaded;
  logic [NUM_PE*CTRL_W-1:0] pe_ctrl;
  logic [NUM_PE-1:0]        pe_en;
  logic [1:0]               ctx_idx;

  int n_checks = 0;
  int n_pass   = 0;

  logic [CTRL_W-1:0] exp_mem [NUM_CTX][NUM_PE];
  logic [CTRL_W-1:0] new_mem [NUM_CTX][NUM_PE];

  pe_array_sequencer #(.NUM_PE(NUM_PE), .NUM_CTX(NUM_CTX), .CTRL_W(CTRL_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .start     (start),
    .run_len   (run_len),
    .stop      (stop),
    .pe_ctrl   (pe_ctrl),
    .pe_en     (pe_en),
    .res_valid (res_valid),
    .busy      (busy),
    .done      (done),
    .cfg_loaded(cfg_loaded),
    .ctx_idx   (ctx_idx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [NUM_PE*CTRL_W-1:0] ctx_word(input int c);
    logic [NUM_PE*CTRL_W-1:0] r;
    for (int p = 0; p < NUM_PE; p++) r[p*CTRL_W +: CTRL_W] = exp_mem[c][p];
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pe_en"}, pe_en, 0);
    chk({tag, "_pe_ctrl"}, pe_ctrl, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cfg_loaded"}, cfg_loaded, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_ctx_idx"}, ctx_idx, 0);
  endtask

  // directed: word for ctx c, pe i is {c,i}; junk: nibbles sent before a restart pulse;
  // abort_at: reset once that many nibbles are in (negative = never).
  task automatic load_cfg(input bit directed, input int junk, input int abort_at);
    int accepts;
    int w;
    logic [7:0] b;
    for (int c = 0; c < NUM_CTX; c++)
      for (int p = 0; p < NUM_PE; p++)
        new_mem[c][p] = directed ? 8'((c << 4) | p) : 8'($urandom);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    for (int j = 0; j < junk; j++) begin
      cfg_valid = 1'b1;
      cfg_data  = 4'($urandom);
      tick();
    end
    cfg_load = 1'b1;
    tick();
    cfg_load  = 1'b0;
    cfg_valid = 1'b0;
    accepts   = 0;
    for (int j = 0; j < NIBS; j++) begin
      if (j == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_cfg_loaded", cfg_loaded, 0);
        chk("abort_cfg_ready", cfg_ready, 0);
        chk("abort_busy", busy, 0);
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        cfg_valid = 1'b0;
        cfg_data  = 4'($urandom);
        start     = 1'($urandom);
        tick();
      end
      start     = 1'b0;
      w         = j >> 1;
      b         = new_mem[w / NUM_PE][w % NUM_PE];
      cfg_valid = 1'b1;
      cfg_data  = (j & 1) ? b[7:4] : b[3:0];
      if (cfg_ready) accepts++;
      tick();
    end
    cfg_valid = 1'b0;
    exp_mem   = new_mem;
    chk("load_accepts", accepts, NIBS);
    chk("load_cfg_loaded", cfg_loaded, 1);
    chk("load_cfg_ready_after", cfg_ready, 0);
    cfg_valid = 1'b1;
    tick();
    chk("load_ready_stays_low", cfg_ready, 0);
    cfg_valid = 1'b0;
  endtask

  // stop_at: run cycle (1..N) at which stop is raised, 0 for a full run.
  task automatic run_check(input int rl, input int stop_at);
    int n, m;
    n = (rl == 0) ? 16 : rl;
    m = (stop_at > 0 && stop_at <= n) ? stop_at : n;
    start   = 1'b1;
    run_len = 4'(rl);
    tick();
    start = 1'b0;
    for (int k = 1; k <= m + 3; k++) begin
      chk($sformatf("pe_en[%0d]", k), pe_en, (k <= m) ? {NUM_PE{1'b1}} : '0);
      chk($sformatf("pe_ctrl[%0d]", k), pe_ctrl, (k <= m) ? ctx_word((k - 1) % NUM_CTX) : '0);
      chk($sformatf("res_valid[%0d]", k), res_valid, (k >= 2 && k <= m + 1));
      chk($sformatf("busy[%0d]", k), busy, (k <= m + 1));
      chk($sformatf("done[%0d]", k), done, (k == m + 2));
      if (k <= m) chk($sformatf("ctx_idx[%0d]", k), ctx_idx, (k - 1) % NUM_CTX);
      start    = (k <= m + 1) ? 1'($urandom) : 1'b0;
      cfg_load = (k <= m + 1) ? 1'($urandom) : 1'b0;
      stop     = (k == stop_at) || (k == m + 1 && 1'($urandom));
      tick();
    end
    start    = 1'b0;
    cfg_load = 1'b0;
    stop     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    start = 1'b0; run_len = '0; stop = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_all_zero("reset");

    start   = 1'b1;
    run_len = 4'd3;
    tick();
    start = 1'b0;
    chk("unloaded_start_busy", busy, 0);
    chk("unloaded_start_pe_en", pe_en, 0);
    cfg_load = 1'b1;
    start    = 1'b1;
    tick();
    cfg_load = 1'b0;
    start    = 1'b0;
    chk("load_wins_cfg_ready", cfg_ready, 1);
    chk("load_wins_busy", busy, 0);
    chk("load_wins_cfg_loaded", cfg_loaded, 0);

    load_cfg(1'b1, 0, -1);
    run_check(6, 0);
    run_check(0, 0);
    run_check(10, 3);

    load_cfg(1'b0, 2, 17);
    load_cfg(1'b0, 3, -1);
    run_check(0, 0);

    start   = 1'b1;
    run_len = 4'd10;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("rst_run");
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      chk($sformatf("rst_run_no_done[%0d]", i), done, 0);
      chk($sformatf("rst_run_no_busy[%0d]", i), busy, 0);
    end
    start = 1'b0;

    for (int it = 0; it < 6; it++) begin
      load_cfg(1'b0, $urandom_range(0, 4), -1);
      for (int r = 0; r < 3; r++) begin
        int rl, n;
        rl = $urandom_range(0, 15);
        n  = (rl == 0) ? 16 : rl;
        run_check(rl, ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_array_sequencer.md
PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

Interface
REQ-001 Parameter NUM_PE, default 4, number of PEs driven.
REQ-002 Parameter NUM_CTX, default 4, number of stored context words per PE.
REQ-003 Parameter CTRL_W, default 8, PE control word width: [7:5] sel_op_0, [4:2] sel_op_1, [1:0] alu_op.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cfg_load  in  1  pulse, enter LOAD and restart the write pointer.
REQ-008 cfg_valid  in  1  cfg_data is valid.
REQ-009 cfg_data  in  4  configuration nibble, low nibble of each word first.
REQ-010 cfg_ready  out  1  sequencer accepts a nibble; high only in LOAD.
REQ-011 start  in  1  begin a run (IDLE only).
REQ-012 run_len  in  4  number of compute steps, sampled with start; 0 encodes 16.
REQ-013 stop  in  1  abort the run in progress.
REQ-014 pe_ctrl  out  NUM_PE*CTRL_W  per-PE control word; PE i occupies bits [i*CTRL_W +: CTRL_W].
REQ-015 pe_en  out  NUM_PE  per-PE enable; all bits move together.
REQ-016 res_valid  out  1  PE outputs hold a valid result this cycle.
REQ-017 busy  out  1  run in progress (RUN or DRAIN).
REQ-018 done  out  1  one-cycle pulse when a run ends.
REQ-019 cfg_loaded  out  1  the full context memory holds a complete configuration.
REQ-020 ctx_idx  out  $clog2(NUM_CTX)  context currently presented on pe_ctrl.

Function
REQ-021 FSM states SHALL be IDLE, LOAD, RUN and DRAIN; all outputs SHALL be registered.
REQ-022 IDLE to LOAD on cfg_load: the write pointer SHALL clear to 0 and cfg_loaded SHALL clear.
REQ-023 In LOAD, a nibble SHALL be accepted on a cycle where cfg_valid and cfg_ready are both high.
REQ-024 Nibble order SHALL be: ctx0 pe0 low, ctx0 pe0 high, ctx0 pe1 low, and so on through ctx(NUM_CTX-1) pe(NUM_PE-1) high.
REQ-025 When the final nibble (2*NUM_PE*NUM_CTX, 32 by default) is accepted, the FSM SHALL go to IDLE and cfg_loaded SHALL be 1 on the next cycle.
REQ-026 cfg_load asserted while in LOAD SHALL restart the write pointer at 0; start in LOAD SHALL be ignored.
REQ-027 start in IDLE with cfg_loaded=0 SHALL be ignored; if cfg_load and start are high together, cfg_load SHALL win.
REQ-028 Let start be accepted at edge E0 and N be the effective run_len. pe_en SHALL be all-ones on cycles 1..N, and pe_ctrl SHALL present context (k-1) mod NUM_CTX on cycle k.
REQ-029 ctx_idx SHALL start at 0 on every run and wrap from NUM_CTX-1 to 0.
REQ-030 res_valid SHALL be high on cycles 2..N+1, one cycle after each pe_en cycle, matching the PE operand-register latency.
REQ-031 busy SHALL be high on cycles 1..N+1; done SHALL pulse on cycle N+2 with the FSM back in IDLE.
REQ-032 stop sampled high during RUN at cycle k: pe_en SHALL be 0 from cycle k+1, DRAIN SHALL produce the final res_valid at k+1, and done SHALL pulse at k+2.
REQ-033 stop in DRAIN SHALL have no effect, as SHALL cfg_load and start in RUN or DRAIN.
REQ-034 Outside RUN, pe_en SHALL be 0 and pe_ctrl SHALL be 0.
REQ-035 Context memory SHALL retain its contents across runs, so repeated start needs no reload.

Reset
REQ-036 On reset: FSM=IDLE; pe_en, pe_ctrl, res_valid, busy, done, cfg_loaded, cfg_ready and ctx_idx SHALL be 0; the write pointer SHALL be 0.
REQ-037 Context memory SHALL need no reset; cfg_loaded=0 SHALL guard against running stale contents.
REQ-038 Reset asserted mid-LOAD or mid-RUN SHALL take effect at the next edge with no done pulse.

Structure
REQ-039 Package pe_cfg_pkg SHALL hold NUM_PE, NUM_CTX, CTRL_W, the ctrl field bit positions and the state enum.
REQ-040 Sub-module pe_ctx_mem SHALL provide NUM_CTX x NUM_PE x CTRL_W storage with one nibble write port and one whole-context read port.

Verification
REQ-041 Load words ctx c pe i = {c,i} (e.g. 0x00, 0x01 .. 0x33) with cfg_valid gaps -> exactly 32 accepts, cfg_loaded=1, cfg_ready=0 afterwards.
REQ-042 start with run_len=6 -> pe_en high 6 cycles; ctx_idx 0,1,2,3,0,1; pe_ctrl pe2 = 0x02,0x12,0x22,0x32,0x02,0x12; res_valid cycles 2..7; done at cycle 8.
REQ-043 run_len=0 -> 16 pe_en cycles and done at cycle 18.
REQ-044 stop at run cycle 3 with run_len=10 -> pe_en cycles 1..3, res_valid 2..4, done at cycle 5.
REQ-045 start before any load, then cfg_load and start together -> no run; FSM in LOAD; cfg_loaded=0.
REQ-046 Reset at nibble 17 then a fresh full load -> memory matches the second load only; reset mid-RUN -> all outputs 0 next cycle and no done pulse.
